// File: rtl/fft_vis_pkg.sv
// Shared definitions for the FFT magnitude stage and the VGA spectrum visualizer.
// Holds the frame geometry (N_POINTS, ADDR_W), the magnitude width (MAG_W) and
// the frame-alignment FSM state type.
package fft_vis_pkg;

  localparam int unsigned N_POINTS = 512;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned MAG_W    = 24;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } frame_state_e;

endpackage

// File: rtl/fft_magnitude_stream_if.sv
// Bin-stream interface between the FFT core, the magnitude stage and the visualizer.
// Signals:
//   i_re, i_im     signed complex bin from the FFT core
//   i_valid, i_sop bin qualifier and start-of-frame marker (no backpressure)
//   o_fft_addr     bin index of o_fft_mag
//   o_fft_mag      unsigned magnitude
//   o_fft_valid    output qualifier
//   o_frame_done   pulse with the last bin of a frame
//   o_sync_err     sticky frame-alignment error
// Modports: master drives the bins and observes results; slave is the magnitude stage.
interface fft_magnitude_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MAG_W  = fft_vis_pkg::MAG_W,
  parameter int unsigned ADDR_W = fft_vis_pkg::ADDR_W
);

  logic signed [DATA_W-1:0] i_re;
  logic signed [DATA_W-1:0] i_im;
  logic                     i_valid;
  logic                     i_sop;
  logic [ADDR_W-1:0]        o_fft_addr;
  logic [MAG_W-1:0]         o_fft_mag;
  logic                     o_fft_valid;
  logic                     o_frame_done;
  logic                     o_sync_err;

  modport master (
    output i_re, i_im, i_valid, i_sop,
    input  o_fft_addr, o_fft_mag, o_fft_valid, o_frame_done, o_sync_err
  );

  modport slave (
    input  i_re, i_im, i_valid, i_sop,
    output o_fft_addr, o_fft_mag, o_fft_valid, o_frame_done, o_sync_err
  );

endinterface

// File: rtl/fft_mag_approx.sv
// Three-stage alpha-max-beta-min magnitude pipeline with a valid sideband.
//   stage 1: saturated |re|, |im|
//   stage 2: max / min
//   stage 3: mx + mn/4 + mn/8, left shift by GAIN_SHIFT, saturate to MAG_W
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears valid and data)
//   i_re, i_im signed input sample, i_valid qualifies it
//   o_mag      unsigned magnitude, o_valid qualifies it (3 cycles after i_valid)
module fft_mag_approx #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAG_W      = 24,
  parameter int unsigned GAIN_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  input  logic                     i_valid,
  output logic [MAG_W-1:0]         o_mag,
  output logic                     o_valid
);

  localparam int unsigned ABS_W = DATA_W - 1;
  localparam int unsigned RAW_W = DATA_W + 1;
  localparam int unsigned SH_W  = RAW_W + GAIN_SHIFT;

  function automatic logic [ABS_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1]) return x[ABS_W-1:0];
    // Only the most-negative input negates back to a negative value.
    if (neg[DATA_W-1]) return '1;
    return neg[ABS_W-1:0];
  endfunction

  logic [ABS_W-1:0] r_abs_re, r_abs_im, r_mx, r_mn;
  logic             r_v1, r_v2, r_v3;
  logic [MAG_W-1:0] r_mag;
  logic [RAW_W-1:0] w_raw;
  logic [SH_W-1:0]  w_shifted;
  logic [MAG_W-1:0] w_mag;

  assign w_raw     = RAW_W'(r_mx) + RAW_W'(r_mn >> 2) + RAW_W'(r_mn >> 3);
  assign w_shifted = SH_W'(w_raw) << GAIN_SHIFT;

  generate
    if (SH_W > MAG_W) begin : g_sat
      assign w_mag = (|w_shifted[SH_W-1:MAG_W]) ? '1 : w_shifted[MAG_W-1:0];
    end else begin : g_ext
      assign w_mag = MAG_W'(w_shifted);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_abs_re <= '0;
      r_abs_im <= '0;
      r_mx     <= '0;
      r_mn     <= '0;
      r_mag    <= '0;
    end else begin
      r_v1     <= i_valid;
      r_abs_re <= sat_abs(i_re);
      r_abs_im <= sat_abs(i_im);
      r_v2     <= r_v1;
      if (r_abs_re >= r_abs_im) begin
        r_mx <= r_abs_re;
        r_mn <= r_abs_im;
      end else begin
        r_mx <= r_abs_im;
        r_mn <= r_abs_re;
      end
      r_v3  <= r_v2;
      r_mag <= w_mag;
    end
  end

  assign o_mag   = r_mag;
  assign o_valid = r_v3;

endmodule

// File: rtl/fft_magnitude_stream.sv
// Streaming magnitude stage between the FFT core and the VGA spectrum visualizer.
// Tracks frame alignment (IDLE/STREAM), numbers accepted bins, runs them through
// fft_mag_approx and pipelines the bin address alongside. Latency 3 cycles.
// Optional feature macro PEAK_HOLD_EN: adds an N_POINTS x MAG_W peak RAM with
// decay (out = max(new, old - old>>DECAY_SHIFT)); latency becomes 4.
// Ports:
//   clk     clock (FFT / visualizer write domain)
//   rst     synchronous active-high reset
//   io_bus  slave side of fft_magnitude_stream_if (bins in, magnitudes out)
module fft_magnitude_stream
  import fft_vis_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAG_W       = fft_vis_pkg::MAG_W,
  parameter int unsigned N_POINTS    = fft_vis_pkg::N_POINTS,
  parameter int unsigned ADDR_W      = fft_vis_pkg::ADDR_W,
  parameter int unsigned GAIN_SHIFT  = 4,
  parameter int unsigned DECAY_SHIFT = 4
) (
  input logic                    clk,
  input logic                    rst,
  fft_magnitude_stream_if.slave  io_bus
);

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_POINTS - 1);

  generate
    if (GAIN_SHIFT > 7 || DECAY_SHIFT >= MAG_W || N_POINTS < 8 ||
        (32'd1 << ADDR_W) != N_POINTS) begin : g_bad_param
      $error("fft_magnitude_stream: illegal parameter combination");
    end
  endgenerate

  frame_state_e      r_state, w_state_next;
  logic [ADDR_W-1:0] r_bin_cnt, w_bin_cnt_next, w_acc_addr;
  logic              w_accept, w_sync_set, r_sync_err;
  logic [ADDR_W-1:0] r_addr_s1, r_addr_s2, r_addr_s3;
  logic              r_last_s1, r_last_s2, r_last_s3;
  logic [MAG_W-1:0]  w_mag;
  logic              w_mag_valid;

  always_comb begin
    w_state_next   = r_state;
    w_bin_cnt_next = r_bin_cnt;
    w_accept       = 1'b0;
    w_acc_addr     = '0;
    w_sync_set     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.i_valid) begin
          if (io_bus.i_sop) begin
            w_accept       = 1'b1;
            w_bin_cnt_next = ADDR_W'(1);
            w_state_next   = StStream;
          end else begin
            w_sync_set = 1'b1;  // unaligned sample is dropped
          end
        end
      end
      StStream: begin
        if (io_bus.i_valid) begin
          w_accept = 1'b1;
          if (io_bus.i_sop && r_bin_cnt != '0) begin
            // Early start of frame: restart numbering, partial frame stays emitted.
            w_sync_set     = 1'b1;
            w_bin_cnt_next = ADDR_W'(1);
          end else begin
            w_acc_addr = r_bin_cnt;
            if (r_bin_cnt == LAST_BIN) begin
              w_bin_cnt_next = '0;
              w_state_next   = StIdle;
            end else begin
              w_bin_cnt_next = r_bin_cnt + 1'b1;
            end
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_bin_cnt  <= '0;
      r_sync_err <= 1'b0;
      r_addr_s1  <= '0;
      r_addr_s2  <= '0;
      r_addr_s3  <= '0;
      r_last_s1  <= 1'b0;
      r_last_s2  <= 1'b0;
      r_last_s3  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bin_cnt  <= w_bin_cnt_next;
      r_sync_err <= r_sync_err | w_sync_set;
      r_addr_s1  <= w_acc_addr;
      r_addr_s2  <= r_addr_s1;
      r_addr_s3  <= r_addr_s2;
      r_last_s1  <= w_accept && (w_acc_addr == LAST_BIN);
      r_last_s2  <= r_last_s1;
      r_last_s3  <= r_last_s2;
    end
  end

  fft_mag_approx #(
    .DATA_W     (DATA_W),
    .MAG_W      (MAG_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_mag (
    .clk     (clk),
    .rst     (rst),
    .i_re    (io_bus.i_re),
    .i_im    (io_bus.i_im),
    .i_valid (w_accept),
    .o_mag   (w_mag),
    .o_valid (w_mag_valid)
  );

`ifdef PEAK_HOLD_EN
  // Peak RAM has no reset; r_first_frame forces out = new until a full frame is written.
  logic [MAG_W-1:0]  r_peak_ram [N_POINTS];
  logic [MAG_W-1:0]  r_old_s2, r_old_s3, w_decayed, w_held;
  logic [MAG_W-1:0]  r_out_mag;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid, r_out_done, r_first_frame;

  assign w_decayed = r_old_s3 - (r_old_s3 >> DECAY_SHIFT);
  assign w_held    = (r_first_frame || w_mag >= w_decayed) ? w_mag : w_decayed;

  always_ff @(posedge clk) begin
    r_old_s2 <= r_peak_ram[r_addr_s1];
    r_old_s3 <= r_old_s2;
    if (w_mag_valid) r_peak_ram[r_addr_s3] <= w_held;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_mag     <= '0;
      r_out_addr    <= '0;
      r_out_valid   <= 1'b0;
      r_out_done    <= 1'b0;
      r_first_frame <= 1'b1;
    end else begin
      r_out_mag   <= w_held;
      r_out_addr  <= r_addr_s3;
      r_out_valid <= w_mag_valid;
      r_out_done  <= w_mag_valid & r_last_s3;
      if (w_mag_valid && r_last_s3) r_first_frame <= 1'b0;
    end
  end

  assign io_bus.o_fft_mag    = r_out_mag;
  assign io_bus.o_fft_addr   = r_out_addr;
  assign io_bus.o_fft_valid  = r_out_valid;
  assign io_bus.o_frame_done = r_out_done;
`else
  assign io_bus.o_fft_mag    = w_mag;
  assign io_bus.o_fft_addr   = r_addr_s3;
  assign io_bus.o_fft_valid  = w_mag_valid;
  assign io_bus.o_frame_done = w_mag_valid & r_last_s3;
`endif

  assign io_bus.o_sync_err = r_sync_err;

endmodule

// File: tb/tb_fft_magnitude_stream.sv
// Self-checking bench for fft_magnitude_stream. Two instances share one input
// stream: A (MAG_W=24, GAIN_SHIFT=4) and B (MAG_W=20, GAIN_SHIFT=7, saturating).
// Expected outputs come from a behavioural model of the frame rules and the
// magnitude formula; the PEAK_HOLD_EN macro selects the peak-hold model too.
module tb_fft_magnitude_stream;

  localparam int P = 10;
  localparam int N = 512;
`ifdef PEAK_HOLD_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_magnitude_stream_if #(.DATA_W(16), .MAG_W(24), .ADDR_W(9)) bus_a ();
  fft_magnitude_stream_if #(.DATA_W(16), .MAG_W(20), .ADDR_W(9)) bus_b ();

  assign bus_b.i_re    = bus_a.i_re;
  assign bus_b.i_im    = bus_a.i_im;
  assign bus_b.i_valid = bus_a.i_valid;
  assign bus_b.i_sop   = bus_a.i_sop;

  fft_magnitude_stream #(
    .DATA_W(16), .MAG_W(24), .N_POINTS(512), .ADDR_W(9), .GAIN_SHIFT(4), .DECAY_SHIFT(4)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_a)
  );

  fft_magnitude_stream #(
    .DATA_W(16), .MAG_W(20), .N_POINTS(512), .ADDR_W(9), .GAIN_SHIFT(7), .DECAY_SHIFT(4)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b)
  );

  typedef struct {
    time    due;
    int     addr;
    longint mag_a;
    longint mag_b;
    bit     done;
  } exp_t;

  exp_t   q[$];
  int     n_assert = 0;
  int     n_fail   = 0;
  int     missed   = 0;
  bit     mon_en   = 1'b0;
  bit     m_stream = 1'b0;
  int     m_cnt    = 0;
  bit     m_err    = 1'b0;
  bit     m_first  = 1'b1;
  longint peak_a [N];
  longint peak_b [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint mag_ref(input int re, input int im, input int gain, input int magw);
    longint ar, ai, mx, mn, v, lim;
    ar = (re < 0) ? -longint'(re) : longint'(re);
    ai = (im < 0) ? -longint'(im) : longint'(im);
    if (ar > 32767) ar = 32767;
    if (ai > 32767) ai = 32767;
    mx  = (ar > ai) ? ar : ai;
    mn  = (ar > ai) ? ai : ar;
    v   = (mx + mn / 4 + mn / 8) * (longint'(1) << gain);
    lim = (longint'(1) << magw) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic longint hold(input longint nw, input longint old, input bit first);
    longint dec;
    dec = old - old / 16;
    if (first || nw >= dec) return nw;
    return dec;
  endfunction

  // Applies the frame rules to one sample taken at the current rising edge.
  task automatic model(input bit v, input bit s, input int re, input int im);
    exp_t e;
    bit   acc;
    int   addr;
    acc  = 1'b0;
    addr = 0;
    if (v) begin
      if (!m_stream) begin
        if (s) begin
          acc = 1'b1; addr = 0; m_stream = 1'b1; m_cnt = 1;
        end else begin
          m_err = 1'b1;
        end
      end else if (s && m_cnt != 0) begin
        m_err = 1'b1; acc = 1'b1; addr = 0; m_cnt = 1;
      end else begin
        acc = 1'b1; addr = m_cnt;
        if (m_cnt == N - 1) begin
          m_stream = 1'b0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    if (acc) begin
      e.due   = $time + time'((LAT - 1) * P + P / 2);
      e.addr  = addr;
      e.done  = (addr == N - 1);
      e.mag_a = mag_ref(re, im, 4, 24);
      e.mag_b = mag_ref(re, im, 7, 20);
`ifdef PEAK_HOLD_EN
      e.mag_a = hold(e.mag_a, peak_a[addr], m_first);
      e.mag_b = hold(e.mag_b, peak_b[addr], m_first);
      peak_a[addr] = e.mag_a;
      peak_b[addr] = e.mag_b;
      if (addr == N - 1) m_first = 1'b0;
`endif
      q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input bit s, input int re, input int im);
    @(negedge clk);
    bus_a.i_valid = v;
    bus_a.i_sop   = s;
    bus_a.i_re    = 16'(re);
    bus_a.i_im    = 16'(im);
    @(posedge clk);
    model(v, s, re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_reset();
    chk("rst_addr_a", 32'(bus_a.o_fft_addr), 0);
    chk("rst_mag_a", 32'(bus_a.o_fft_mag), 0);
    chk("rst_valid_a", 32'(bus_a.o_fft_valid), 0);
    chk("rst_done_a", 32'(bus_a.o_frame_done), 0);
    chk("rst_err_a", 32'(bus_a.o_sync_err), 0);
    chk("rst_addr_b", 32'(bus_b.o_fft_addr), 0);
    chk("rst_mag_b", 32'(bus_b.o_fft_mag), 0);
    chk("rst_valid_b", 32'(bus_b.o_fft_valid), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst           = 1'b1;
    bus_a.i_valid = 1'b0;
    bus_a.i_sop   = 1'b0;
    @(posedge clk);
    q.delete();
    m_stream = 1'b0;
    m_cnt    = 0;
    m_err    = 1'b0;
    m_first  = 1'b1;
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset();
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Sends bins [from, to) of a frame; sop on bin 0; optional random gaps; forced bins.
  task automatic frame(input int from, input int to, input bit gaps,
                       input int fbin, input int fre, input int fim);
    int re, im;
    for (int b = from; b < to; b++) begin
      if (gaps && b > 0 && $urandom_range(3) == 0) step(1'b0, 1'b0, 0, 0);
      re = rnd16();
      im = rnd16();
      if (b == 3) begin re = -32768; im = -32768; end
      if (b == fbin) begin re = fre; im = fim; end
      step(1'b1, b == 0, re, im);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit   ev;
    if (mon_en) begin
      while (q.size() > 0 && q[0].due < $time) begin
        missed++;
        void'(q.pop_front());
      end
      ev = (q.size() > 0 && q[0].due == $time);
      if (ev) e = q.pop_front();
      chk("valid_a", 32'(bus_a.o_fft_valid), 32'(ev));
      chk("valid_b", 32'(bus_b.o_fft_valid), 32'(ev));
      chk("done_a", 32'(bus_a.o_frame_done), 32'(ev && e.done));
      chk("done_b", 32'(bus_b.o_frame_done), 32'(ev && e.done));
      chk("sync_err_a", 32'(bus_a.o_sync_err), 32'(m_err));
      chk("sync_err_b", 32'(bus_b.o_sync_err), 32'(m_err));
      if (ev) begin
        chk("addr_a", 32'(bus_a.o_fft_addr), 32'(e.addr));
        chk("addr_b", 32'(bus_b.o_fft_addr), 32'(e.addr));
        chk("mag_a", 32'(bus_a.o_fft_mag), 32'(e.mag_a));
        chk("mag_b", 32'(bus_b.o_fft_mag), 32'(e.mag_b));
      end
    end
  end

  initial begin
    int re, im;
    bus_a.i_valid = 1'b0;
    bus_a.i_sop   = 1'b0;
    bus_a.i_re    = '0;
    bus_a.i_im    = '0;
    do_reset(2);
    mon_en = 1'b1;

    // Frame 1: constant 1000+0j, no gaps (bin 5 -> 16000 on A).
    for (int b = 0; b < N; b++) step(1'b1, b == 0, 1000, 0);
    // Frame 2 back-to-back: random with gaps, bin 5 forced to zero.
    frame(0, N, 1'b1, 5, 0, 0);
    // Frame 3: bin 5 forced to 1250+0j (20000 on A).
    frame(0, N, 1'b1, 5, 1250, 0);
    idle(5);

    // Early sop at bin 100: restart numbering, then complete a full frame.
    frame(0, 100, 1'b1, -1, 0, 0);
    frame(0, N, 1'b1, -1, 0, 0);
    idle(5);

    // Reset at bin 200 with bins in flight.
    frame(0, 200, 1'b0, -1, 0, 0);
    do_reset(1);
    idle(4);

    // Unaligned bursts without sop are dropped and flag a sync error.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        re = rnd16();
        im = rnd16();
        step(1'b1, 1'b0, re, im);
      end
      idle(2);
    end

    // A proper frame still streams normally; the error flag stays set.
    frame(0, N, 1'b1, -1, 0, 0);
    idle(LAT + 3);

    chk("missed_outputs", 32'(missed), 0);
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
